// File: rtl/grid_pkg.sv
// Shared definitions for the grid cursor block: width helper and control FSM states.
package grid_pkg;

  // Width of a field that must hold values 0..n-1; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Control FSM: one-cycle ACCEPT/REJECT pulses, DONE while the whole grid is visited.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_REJECT = 2'd2,
    ST_DONE   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/grid_onehot_dec.sv
// Parametrised 1-to-N demux: drives exactly one bit of sel for idx < N, none otherwise.
module grid_onehot_dec #(
  parameter int N = 36,
  parameter int W = 6
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] sel
);

  // Compare idx against every output position.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == W'(i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/grid_cursor_selector.sv
// Registered cursor over a ROWS x COLS grid with a visited-cell map and
// accept/reject pulses for player confirmations.
module grid_cursor_selector
  import grid_pkg::*;
#(
  parameter int ROWS     = 6,
  parameter int COLS     = 6,
  parameter bit WRAP     = 1'b1,
  parameter int HOME_ROW = 0,
  parameter int HOME_COL = 0,
  localparam int ROW_W   = width_of(ROWS),
  localparam int COL_W   = width_of(COLS),
  localparam int N_CELLS = ROWS * COLS,
  localparam int IDX_W   = width_of(N_CELLS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mv_up,
  input  logic               mv_dn,
  input  logic               mv_lf,
  input  logic               mv_rt,
  input  logic               home,
  input  logic               confirm,
  input  logic               clear_map,
  output logic [ROW_W-1:0]   row,
  output logic [COL_W-1:0]   col,
  output logic [IDX_W-1:0]   idx,
  output logic [N_CELLS-1:0] cell_sel,
  output logic               sel_valid,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               sel_reject,
  output logic               all_visited
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_HOME = ROW_W'(HOME_ROW);
  localparam logic [COL_W-1:0] COL_HOME = COL_W'(HOME_COL);

  logic [ROW_W-1:0]   row_next;
  logic [COL_W-1:0]   col_next;
  logic [N_CELLS-1:0] visited;
  logic               cell_seen;
  logic               accept_now;
  logic               reject_now;
  ctrl_state_t        state;
  ctrl_state_t        state_next;

  // Vertical step: home wins, opposite pulses cancel, edges wrap or clamp.
  always_comb begin
    row_next = row;
    if (home) begin
      row_next = ROW_HOME;
    end else if (mv_up && !mv_dn) begin
      if (row == '0) row_next = WRAP ? ROW_LAST : row;
      else           row_next = row - ROW_W'(1);
    end else if (mv_dn && !mv_up) begin
      if (row == ROW_LAST) row_next = WRAP ? '0 : row;
      else                 row_next = row + ROW_W'(1);
    end
  end

  // Horizontal step: same rules as the vertical axis, evaluated independently.
  always_comb begin
    col_next = col;
    if (home) begin
      col_next = COL_HOME;
    end else if (mv_lf && !mv_rt) begin
      if (col == '0) col_next = WRAP ? COL_LAST : col;
      else           col_next = col - COL_W'(1);
    end else if (mv_rt && !mv_lf) begin
      if (col == COL_LAST) col_next = WRAP ? '0 : col;
      else                 col_next = col + COL_W'(1);
    end
  end

  // Cursor register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= ROW_HOME;
      col <= COL_HOME;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples
      // the pre-edge values of the others, independent of statement order.
      row <= row_next;
      col <= col_next;
    end
  end

  // Linear index at full IDX_W width; row/col never exceed their last value,
  // so idx stays below ROWS*COLS.
  assign idx = (IDX_W'(row) * IDX_W'(COLS)) + IDX_W'(col);

  grid_onehot_dec #(
    .N (N_CELLS),
    .W (IDX_W)
  ) u_dec (
    .idx (idx),
    .sel (cell_sel)
  );

  // Confirm decisions use the pre-move cursor of the same cycle; clear_map and
  // a full map both suppress them.
  assign cell_seen  = |(visited & cell_sel);
  assign accept_now = confirm && !clear_map && !all_visited && !cell_seen;
  assign reject_now = confirm && !clear_map && !all_visited &&  cell_seen;

  // Visited map, full-map flag and captured selection index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the map is a plain flop vector, so it is reset here; a reset
      // mid-game must forget every visited cell at once.
      visited     <= '0;
      all_visited <= 1'b0;
      sel_idx     <= '0;
    end else if (clear_map) begin
      visited     <= '0;
      all_visited <= 1'b0;
    end else if (accept_now) begin
      visited     <= visited | cell_sel;
      all_visited <= &(visited | cell_sel);
      sel_idx     <= idx;
    end
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Control FSM next state.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_ACCEPT, ST_REJECT: begin
        if (clear_map)       state_next = ST_IDLE;
        else if (all_visited) state_next = ST_DONE;
        else if (accept_now) state_next = ST_ACCEPT;
        else if (reject_now) state_next = ST_REJECT;
        else                 state_next = ST_IDLE;
      end
      ST_DONE: begin
        if (clear_map) state_next = ST_IDLE;
      end
    endcase
  end

  // Control FSM outputs: one-cycle pulses straight from the state.
  always_comb begin
    sel_valid  = 1'b0;
    sel_reject = 1'b0;
    unique case (state)
      ST_ACCEPT: sel_valid  = 1'b1;
      ST_REJECT: sel_reject = 1'b1;
      ST_IDLE, ST_DONE: ;
    endcase
  end

endmodule
